// File: rtl/get_digests_request.sv
// get_digests_request: initiator side of the GET_DIGESTS/DIGESTS exchange.
// Optional build macro DIGESTS_RETRY_EN re-issues a timed-out request up to MAX_RETRIES times.
module get_digests_request #(
    parameter int HDR_W          = 32,
    parameter int DIGEST_W       = 32,
    parameter int NUM_SLOTS      = 3,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRIES    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          req_ack,
    input  logic                          rsp_ack,
    input  logic [HDR_W-1:0]              rsp_header,
    input  logic [NUM_SLOTS*DIGEST_W-1:0] rsp_payload,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [2:0]                    err_code,
    output logic [7:0]                    slot_mask,
    output logic [NUM_SLOTS*DIGEST_W-1:0] digests
);

    localparam int               PAY_W     = NUM_SLOTS * DIGEST_W;
    localparam int               CNT_W     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       SLOT_BITS = 8'((1 << NUM_SLOTS) - 1);

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_VERSION   = 3'd1;
    localparam logic [2:0] ERR_MSG_TYPE  = 3'd2;
    localparam logic [2:0] ERR_SLOT_MASK = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DONE,
        S_ERR
`ifdef DIGESTS_RETRY_EN
        , S_RETRY
`endif
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  timer;
    logic [2:0]        hdr_code;
    logic [PAY_W-1:0]  masked_payload;
    logic [7:0]        hdr_version;
    logic [7:0]        hdr_msg_type;
    logic [7:0]        hdr_param2;
    logic              unused_param1;

`ifdef DIGESTS_RETRY_EN
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RETRY_W-1:0] retry_cnt;
`else
    localparam int UNUSED_MAX_RETRIES = MAX_RETRIES;
`endif

    assign hdr_version   = rsp_header[HDR_W-1 -: 8];
    assign hdr_msg_type  = rsp_header[HDR_W-9 -: 8];
    assign hdr_param2    = rsp_header[7:0];
    assign unused_param1 = ^rsp_header[HDR_W-17 -: 8];

    always_comb begin
        hdr_code = ERR_NONE;
        if (hdr_version != 8'h01)
            hdr_code = ERR_VERSION;
        else if (hdr_msg_type != 8'h01)
            hdr_code = ERR_MSG_TYPE;
        else if (hdr_param2 == 8'h00 || (hdr_param2 & ~SLOT_BITS) != 8'h00)
            hdr_code = ERR_SLOT_MASK;
    end

    // Slot 0 sits in the MSBs; slots not named in Param2 are reported as zero.
    always_comb begin
        masked_payload = '0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (hdr_param2[i])
                masked_payload[(NUM_SLOTS-i)*DIGEST_W-1 -: DIGEST_W] =
                    rsp_payload[(NUM_SLOTS-i)*DIGEST_W-1 -: DIGEST_W];
    end

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // branch sees the pre-edge values of state, timer and retry_cnt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            timer     <= '0;
            req_ack   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err_code  <= ERR_NONE;
            slot_mask <= 8'h00;
            digests   <= '0;
`ifdef DIGESTS_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_WAIT;
                        req_ack <= 1'b1;
                        busy    <= 1'b1;
                        timer   <= '0;
`ifdef DIGESTS_RETRY_EN
                        retry_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (rsp_ack) begin
                        req_ack  <= 1'b0;
                        err_code <= hdr_code;
                        if (hdr_code == ERR_NONE) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            slot_mask <= hdr_param2;
                            digests   <= masked_payload;
                        end else begin
                            state     <= S_ERR;
                            error     <= 1'b1;
                            slot_mask <= 8'h00;
                            digests   <= '0;
                        end
                    end else if (timer == CNT_LAST) begin
                        req_ack <= 1'b0;
`ifdef DIGESTS_RETRY_EN
                        if (int'(retry_cnt) < MAX_RETRIES) begin
                            state     <= S_RETRY;
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                            timer     <= '0;
                        end else begin
                            state     <= S_ERR;
                            error     <= 1'b1;
                            err_code  <= ERR_TIMEOUT;
                            slot_mask <= 8'h00;
                            digests   <= '0;
                        end
`else
                        state     <= S_ERR;
                        error     <= 1'b1;
                        err_code  <= ERR_TIMEOUT;
                        slot_mask <= 8'h00;
                        digests   <= '0;
`endif
                    end else begin
                        timer <= timer + CNT_W'(1);
                    end
                end
`ifdef DIGESTS_RETRY_EN
                S_RETRY: begin
                    state   <= S_WAIT;
                    req_ack <= 1'b1;
                end
`endif
                S_DONE, S_ERR: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    req_ack <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_get_digests_request.sv
// Self-checking bench for get_digests_request: randomized exchanges against a
// cycle-level reference model, plus hand-computed checks of the listed scenarios.
module tb_get_digests_request;

    localparam int HDR_W          = 32;
    localparam int DIGEST_W       = 32;
    localparam int NUM_SLOTS      = 3;
    localparam int TIMEOUT_CYCLES = 64;
    localparam int MAX_RETRIES    = 2;
    localparam int PAY_W          = NUM_SLOTS * DIGEST_W;
`ifdef DIGESTS_RETRY_EN
    localparam int RETRIES = MAX_RETRIES;
`else
    localparam int RETRIES = 0;
`endif

    localparam logic [PAY_W-1:0] P1 = {32'h04568787, 32'hAC786425, 32'h0F986550};
    localparam logic [PAY_W-1:0] P2_EXP = {32'h00000000, 32'hAC786425, 32'h00000000};

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              rsp_ack;
    logic [HDR_W-1:0]  rsp_header;
    logic [PAY_W-1:0]  rsp_payload;
    logic              req_ack;
    logic              busy;
    logic              done;
    logic              error;
    logic [2:0]        err_code;
    logic [7:0]        slot_mask;
    logic [PAY_W-1:0]  digests;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    get_digests_request #(
        .HDR_W(HDR_W), .DIGEST_W(DIGEST_W), .NUM_SLOTS(NUM_SLOTS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRIES(MAX_RETRIES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .req_ack(req_ack),
        .rsp_ack(rsp_ack), .rsp_header(rsp_header), .rsp_payload(rsp_payload),
        .busy(busy), .done(done), .error(error), .err_code(err_code),
        .slot_mask(slot_mask), .digests(digests)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an exchange is a request that either gets a response or
    // runs out its TIMEOUT_CYCLES window, measured from the edge req_ack rose.
    function automatic bit [2:0] verdict(input bit [31:0] h);
        if (h[31:24] != 8'h01) return 3'd1;
        if (h[23:16] != 8'h01) return 3'd2;
        if (h[7:0] == 8'h00 || int'(h[7:0]) >= (1 << NUM_SLOTS)) return 3'd3;
        return 3'd0;
    endfunction

    function automatic bit [PAY_W-1:0] keep_slots(input bit [7:0] m, input bit [PAY_W-1:0] p);
        bit [PAY_W-1:0] lane;
        bit [PAY_W-1:0] r = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            lane = {{(PAY_W-DIGEST_W){1'b0}}, {DIGEST_W{1'b1}}} << ((NUM_SLOTS - 1 - s) * DIGEST_W);
            if (m[s]) r = r | (p & lane);
        end
        return r;
    endfunction

    bit               e_req, e_busy, e_done, e_error;
    bit [2:0]         e_code;
    bit [7:0]         e_mask;
    bit [PAY_W-1:0]   e_dig;
    bit               waiting, gap, closing;
    int               cyc, deadline, retries_used;

    always @(posedge clk or posedge reset) begin
        bit [2:0] v;
        if (reset) begin
            {e_req, e_busy, e_done, e_error} = '0;
            e_code = '0; e_mask = '0; e_dig = '0;
            {waiting, gap, closing} = '0;
            retries_used = 0;
        end else begin
            cyc++;
            e_done  = 1'b0;
            e_error = 1'b0;
            if (closing) begin
                closing = 1'b0;
                e_busy  = 1'b0;
            end else if (gap) begin
                gap      = 1'b0;
                e_req    = 1'b1;
                deadline = cyc + TIMEOUT_CYCLES;
            end else if (waiting) begin
                v = 3'd7;
                if (rsp_ack) v = verdict(rsp_header);
                else if (cyc == deadline) begin
                    if (retries_used < RETRIES) begin
                        retries_used++;
                        gap   = 1'b1;
                        e_req = 1'b0;
                    end else v = 3'd4;
                end
                if (v != 3'd7) begin
                    waiting = 1'b0;
                    closing = 1'b1;
                    e_req   = 1'b0;
                    e_code  = v;
                    e_done  = (v == 3'd0);
                    e_error = (v != 3'd0);
                    e_mask  = (v == 3'd0) ? rsp_header[7:0] : 8'h00;
                    e_dig   = (v == 3'd0) ? keep_slots(rsp_header[7:0], rsp_payload) : '0;
                end
            end else if (start) begin
                waiting      = 1'b1;
                e_req        = 1'b1;
                e_busy       = 1'b1;
                retries_used = 0;
                deadline     = cyc + TIMEOUT_CYCLES;
            end
        end
    end

    always @(negedge clk) begin
        check("req_ack", req_ack, e_req);
        check("busy", busy, e_busy);
        check("done", done, e_done);
        check("error", error, e_error);
        check("err_code", err_code, e_code);
        check("slot_mask", slot_mask, e_mask);
        check("digests", digests, e_dig);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scenario_one();
        start = 1'b1; tick(); start = 1'b0;
        tick();
        rsp_header = 32'h01010107; rsp_payload = P1; rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check("s1_done", done, 1'b1);
        check("s1_mask", slot_mask, 8'h07);
        check("s1_digests", digests, P1);
        check("s1_code", err_code, 3'd0);
        tick();
        check("s1_busy_clear", busy, 1'b0);
    endtask

    task automatic one_error(input logic [31:0] hdr, input logic [2:0] code);
        start = 1'b1; tick(); start = 1'b0;
        rsp_header = hdr; rsp_payload = P1; rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check("err_flag", error, 1'b1);
        check("err_code_lit", err_code, code);
        check("err_digests", digests, '0);
        check("err_mask", slot_mask, 8'h00);
        tick();
    endtask

    initial begin
        int n, gaps, d;
        bit seen;
        reset = 1'b0; start = 1'b0; rsp_ack = 1'b0; rsp_header = '0; rsp_payload = '0;
        #1 reset = 1'b1;
        repeat (2) tick();
        check("rst_req_ack", req_ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_digests", digests, '0);
        reset = 1'b0;
        tick();

        scenario_one();

        start = 1'b1; tick(); start = 1'b0;
        rsp_header = 32'h01010102; rsp_payload = P1; rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check("s2_done", done, 1'b1);
        check("s2_mask", slot_mask, 8'h02);
        check("s2_digests", digests, P2_EXP);
        tick();

        // A response while idle must leave the held results untouched.
        rsp_header = 32'h01010107; rsp_payload = ~P1; rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check("idle_ack_done", done, 1'b0);
        check("idle_ack_busy", busy, 1'b0);
        check("idle_ack_mask", slot_mask, 8'h02);
        check("idle_ack_digests", digests, P2_EXP);

        one_error(32'h02010107, 3'd1);
        one_error(32'h01810107, 3'd2);
        one_error(32'h01010108, 3'd3);
        one_error(32'h01010100, 3'd3);

        // Silent responder: timeout after every allowed retry.
        start = 1'b1; tick(); start = 1'b0;
        n = 1; gaps = 0; seen = 1'b0;
        while (!seen && n < 1000) begin
            tick();
            n++;
            if (!req_ack && busy && !error) gaps++;
            if (error) seen = 1'b1;
        end
        check("timeout_seen", seen, 1'b1);
        check("timeout_code", err_code, 3'd4);
        check("timeout_latency", n, (TIMEOUT_CYCLES + 1) * (RETRIES + 1));
        check("timeout_gaps", gaps, RETRIES);
        tick();

        // Response on the expiry edge wins; a start pulse while waiting is dropped.
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 1; i < TIMEOUT_CYCLES; i++) begin
            start = (i == 10);
            tick();
        end
        start = 1'b0;
        rsp_header = 32'h01010107; rsp_payload = P1; rsp_ack = 1'b1;
        tick();
        rsp_ack = 1'b0;
        check("expiry_done", done, 1'b1);
        check("expiry_error", error, 1'b0);
        tick();
        tick();
        check("no_queued_start", busy, 1'b0);

        // Reset in the middle of WAIT.
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        check("midrst_req_ack", req_ack, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_mask", slot_mask, 8'h00);
        check("midrst_digests", digests, '0);
        tick();
        reset = 1'b0;
        tick();
        scenario_one();

        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 3)) begin
                rsp_ack = ($urandom_range(0, 2) == 0);
                rsp_header = $urandom;
                tick();
                rsp_ack = 1'b0;
            end
            start = 1'b1; tick(); start = 1'b0;
            d = $urandom_range(0, 12);
            repeat (d) begin
                start = ($urandom_range(0, 5) == 0);
                tick();
            end
            start = 1'b0;
            case ($urandom_range(0, 5))
                0, 1, 2: rsp_header = {8'h01, 8'h01, 8'($urandom), 8'($urandom_range(1, 7))};
                3:       rsp_header = {8'h01 ^ 8'($urandom_range(1, 255)), 8'h01, 16'($urandom)};
                4:       rsp_header = {8'h01, 8'h01 ^ 8'($urandom_range(1, 255)), 16'($urandom)};
                default: rsp_header = {8'h01, 8'h01, 8'($urandom), 8'($urandom_range(0, 1) ? 0 : $urandom_range(8, 255))};
            endcase
            rsp_payload = {$urandom, $urandom, $urandom};
            rsp_ack = 1'b1;
            tick();
            rsp_ack = 1'b0;
            rsp_header = $urandom;
            repeat (2) tick();
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
